// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count,
// sticky error flags, threshold trigger and optional FWFT read.
module fifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1,
  parameter int FWFT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              push_in,
  input  logic              pop_in,
  input  logic [DATA_W-1:0] din,
  input  logic [CNT_W-1:0]  threshold,
  input  logic              clr_err,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              overrun,
  output logic              underrun,
  output logic              thre_trigger
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_empty;
  logic              r_full;
  logic              r_overrun;
  logic              r_underrun;
  logic              r_thre;

  logic              w_pop_ok;
  logic              w_push_ok;
  logic              w_push_rej;
  logic              w_pop_rej;
  logic [CNT_W-1:0]  w_cnt_nxt;

  assign w_pop_ok   = en & pop_in & ~r_empty;
  assign w_push_ok  = en & push_in & (~r_full | w_pop_ok);
  assign w_push_rej = en & push_in & ~w_push_ok;
  assign w_pop_rej  = en & pop_in & ~w_pop_ok;

  // Next occupancy: simultaneous push and pop cancel out
  always_comb begin
    w_cnt_nxt = r_count;
    if (w_push_ok && !w_pop_ok)
      w_cnt_nxt = r_count + CNT_W'(1);
    else if (w_pop_ok && !w_push_ok)
      w_cnt_nxt = r_count - CNT_W'(1);
  end

  // Storage array; never read before written, so no reset
  always_ff @(posedge clk) begin
    if (w_push_ok)
      r_mem[r_wr_ptr] <= din;
  end

  // Pointers, occupancy and derived status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_thre   <= 1'b0;
    end else begin
      if (w_push_ok)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_cnt_nxt;
      r_empty <= (w_cnt_nxt == '0);
      r_full  <= (w_cnt_nxt == CNT_W'(DEPTH));
      r_thre  <= (threshold != '0) &&
                 (w_cnt_nxt >= threshold);
    end
  end

  // Sticky error flags; a new error beats a clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_push_rej)
        r_overrun <= 1'b1;
      else if (clr_err)
        r_overrun <= 1'b0;
      if (w_pop_rej)
        r_underrun <= 1'b1;
      else if (clr_err)
        r_underrun <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dout = r_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_reg
      logic [DATA_W-1:0] r_dout;
      // Registered read port, holds between pops
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          r_dout <= '0;
        else if (w_pop_ok)
          r_dout <= r_mem[r_rd_ptr];
      end
      assign dout = r_dout;
    end
  endgenerate

  assign empty        = r_empty;
  assign full         = r_full;
  assign count        = r_count;
  assign overrun      = r_overrun;
  assign underrun     = r_underrun;
  assign thre_trigger = r_thre;

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO; next generation of the existing 8-bit/16-entry fifo_top.
- Generalised data width, depth and threshold width.
- Adds usable full-depth storage, same-cycle push/pop, occupancy count, sticky error flags with explicit clear, and an optional first-word-fall-through read mode.
- Drop-in buffer between producer/consumer logic on one clock domain.

Parameters:
DATA_W, 8, data word width in bits
DEPTH, 16, number of storage entries; power of two, >= 4; all DEPTH entries usable
CNT_W, $clog2(DEPTH)+1, width of count and threshold (holds 0..DEPTH)
FWFT, 0, 0 = registered read (data one cycle after pop); 1 = first-word-fall-through (head word visible on dout while not empty)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  global enable; push_in/pop_in are ignored while low
push_in  in  1  write request
pop_in  in  1  read request
din  in  DATA_W  write data, sampled on an accepted push
threshold  in  CNT_W  programmable occupancy threshold; 0 disables thre_trigger
clr_err  in  1  single-cycle clear for the overrun/underrun sticky flags
dout  out  DATA_W  read data
empty  out  1  count == 0
full  out  1  count == DEPTH
count  out  CNT_W  current occupancy
overrun  out  1  sticky: push attempted while full and not relieved
underrun  out  1  sticky: pop attempted while empty
thre_trigger  out  1  count >= threshold, with threshold != 0

Behaviour:
- Reset (rst=0, async, immediate): wr/rd pointers=0, count=0, empty=1, full=0, overrun=0, underrun=0, thre_trigger=0, dout=0.
- Reset also aborts any operation in flight. Memory contents are not reset and are never read before being written.
- Acceptance, evaluated each cycle:
  - pop_ok = en & pop_in & !empty
  - push_ok = en & push_in & (!full | pop_ok); at full, a same-cycle pop frees the slot
- Pointers are log2(DEPTH) bits and wrap naturally DEPTH-1 -> 0.
- count update: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
- empty, full and count are registered and consistent in the cycle after the edge.
- Order is strict FIFO across pointer wrap.
- Push and pop both requested while empty: push accepted, pop rejected, underrun sets, count 0->1.
- FWFT=0:
  - dout <= mem[rd_ptr] on pop_ok, so data is valid the cycle after the pop edge.
  - dout holds its value otherwise, including when empty or when en=0.
- FWFT=1:
  - dout = mem[rd_ptr] whenever !empty; pop_ok advances to the next word.
  - dout is don't-care while empty. The bench must check it only when empty=0.
  - A word pushed into an empty FIFO appears on dout the cycle after the push edge.
- overrun sets on the edge where en & push_in & !push_ok; underrun sets where en & pop_in & !pop_ok.
- Sticky-flag clear: flags clear on a clr_err edge. If set and clear coincide, set wins. Rejected requests never change pointers, count or dout.
- en=0: no pointer, count, dout or flag change from push_in/pop_in. clr_err and thre_trigger still operate.
- thre_trigger is registered from the next-state count: it reflects count >= threshold in the same cycle count reaches the value.
  - A change of threshold takes effect at the next edge.
  - Values of threshold > DEPTH never trigger.

Test Plan:
- Reset, then 20 consecutive pushes (DEPTH=16, en=1, din=0..19) -> full=1 and count=16 after push 16; overrun=1 after push 17; count stays 16; pushes 17-20 are discarded.
- Then 17 pops (FWFT=0) -> dout=0..15 in order, each one cycle after its pop; empty=1 after pop 16; underrun=1 after pop 17; dout holds 15.
- threshold=10, push one per cycle from empty -> thre_trigger rises in the cycle count=10. Pop once -> it falls when count=9. threshold=0 -> it stays 0 at all counts.
- At full, push_in=pop_in=1 for 4 cycles -> count stays 16, no overrun, read order preserved across pointer wrap.
- overrun=1, pulse clr_err -> flags clear. Pulse clr_err in the same cycle as a new overflow -> overrun stays 1.
- Mid-fill, drive rst=0 between edges -> all outputs reach reset values without waiting for a clock edge.
- en=0 with pushes -> count unchanged.
- FWFT=1: push 0xA5 into empty FIFO -> dout=0xA5 the next cycle before any pop.
